// File: rtl/sector_io_pkg.sv
// Shared types and constants for the sector transfer sequencer.
package sector_io_pkg;

    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned BUF_AW       = 9;
    localparam int unsigned CNT_W        = 10;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRd,
        StWrf,
        StWrd,
        StDone,
        StAck
    } state_e;

    function automatic logic is_last_byte(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(SECTOR_BYTES - 1);
    endfunction

endpackage

// File: rtl/sector_io_watchdog.sv
// Loadable down-counter; flags a timeout once it has run down without a reload.
module sector_io_watchdog #(
    parameter logic [23:0] TIMEOUT_CYC = 24'hFFFFFF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic expired
);

    // Loading TIMEOUT_CYC-1 makes the abort edge land exactly TIMEOUT_CYC cycles after a reload.
    localparam logic [23:0] RELOAD = (TIMEOUT_CYC == 24'd0) ? 24'd0 : TIMEOUT_CYC - 24'd1;

    logic [23:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= RELOAD;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != 24'd0) begin
            count <= count - 24'd1;
        end
    end

    // A reload in the same cycle wins over expiry.
    assign expired = (count == 24'd0) && !load;

endmodule

// File: rtl/sector_io_ctrl.sv
// Sector transfer sequencer: moves one 512-byte block between the target buffer and storage.
module sector_io_ctrl
    import sector_io_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYC = 24'hFFFFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       io_lba,
    input  logic              io_rd,
    input  logic              io_wr,
    output logic              io_ack,
    output logic [BUF_AW-1:0] sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [7:0]        sd_buff_din,
    output logic [31:0]       blk_lba,
    output logic              blk_req,
    output logic              blk_we,
    input  logic              blk_gnt,
    input  logic              blk_done,
    input  logic              blk_err,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              err
);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             rd_q, rd_prev, wr_q, wr_prev;
    logic             rd_edge, wr_edge;
    logic             rx_hs, tx_hs;
    logic             wd_load, wd_expired;
    logic             abort;

    // Edge detection runs off the registered copy, giving one extra cycle of accept latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q    <= 1'b0;
            rd_prev <= 1'b0;
            wr_q    <= 1'b0;
            wr_prev <= 1'b0;
        end else begin
            rd_q    <= io_rd;
            rd_prev <= rd_q;
            wr_q    <= io_wr;
            wr_prev <= wr_q;
        end
    end

    assign rd_edge = rd_q & ~rd_prev;
    assign wr_edge = wr_q & ~wr_prev;
    assign rx_hs   = rx_valid & rx_ready;
    assign tx_hs   = tx_valid & tx_ready;
    assign abort   = (state != StIdle) && (state != StAck) && (blk_err || wd_expired);

    // Reload on every state change and byte handshake; IDLE keeps it permanently armed.
    always_comb begin
        wd_load = 1'b1;
        unique case (state)
            StIdle:  wd_load = 1'b1;
            StReq:   wd_load = blk_gnt;
            StRd:    wd_load = rx_hs;
            StWrf:   wd_load = 1'b1;
            StWrd:   wd_load = tx_hs;
            StDone:  wd_load = blk_done;
            StAck:   wd_load = 1'b1;
            default: wd_load = 1'b1;
        endcase
    end

    sector_io_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (wd_load),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= StIdle;
            cnt          <= '0;
            io_ack       <= 1'b0;
            sd_buff_addr <= '0;
            sd_buff_dout <= '0;
            sd_buff_wr   <= 1'b0;
            blk_lba      <= '0;
            blk_req      <= 1'b0;
            blk_we       <= 1'b0;
            rx_ready     <= 1'b0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            err          <= 1'b0;
        end else begin
            io_ack     <= 1'b0;
            sd_buff_wr <= 1'b0;
            if (abort) begin
                state    <= StAck;
                io_ack   <= 1'b1;
                err      <= 1'b1;
                blk_req  <= 1'b0;
                rx_ready <= 1'b0;
                tx_valid <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (rd_edge || wr_edge) begin
                            blk_lba      <= io_lba;
                            blk_we       <= ~rd_edge;
                            err          <= 1'b0;
                            cnt          <= '0;
                            sd_buff_addr <= '0;
                            blk_req      <= 1'b1;
                            state        <= StReq;
                        end
                    end
                    StReq: begin
                        if (blk_gnt) begin
                            blk_req <= 1'b0;
                            if (blk_we) begin
                                state <= StWrf;
                            end else begin
                                rx_ready <= 1'b1;
                                state    <= StRd;
                            end
                        end
                    end
                    StRd: begin
                        if (rx_hs) begin
                            sd_buff_addr <= cnt[BUF_AW-1:0];
                            sd_buff_dout <= rx_data;
                            sd_buff_wr   <= 1'b1;
                            cnt          <= cnt + 1'b1;
                            if (is_last_byte(cnt)) begin
                                rx_ready <= 1'b0;
                                state    <= StDone;
                            end
                        end
                    end
                    StWrf: begin
                        // Address for the following byte goes out now so its read data is
                        // ready by the end of the next WRF cycle.
                        tx_data      <= sd_buff_din;
                        sd_buff_addr <= cnt[BUF_AW-1:0] + 1'b1;
                        tx_valid     <= 1'b1;
                        state        <= StWrd;
                    end
                    StWrd: begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            cnt      <= cnt + 1'b1;
                            state    <= is_last_byte(cnt) ? StDone : StWrf;
                        end
                    end
                    StDone: begin
                        if (blk_done) begin
                            io_ack <= 1'b1;
                            state  <= StAck;
                        end
                    end
                    StAck: begin
                        state <= StIdle;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/sector_io_ctrl.md
# sector_io_ctrl

Sector transfer sequencer between the SCSI target's sector-request interface and the SD-card block storage engine. On an `io_rd` or `io_wr` rising edge it issues one 512-byte block request at `io_lba` and streams the bytes. Reads go storage → target buffer through `sd_buff_*`; writes go target buffer → storage. When the transfer ends it pulses `io_ack`. It sits directly downstream of the target and consumes its `io_lba`/`io_rd`/`io_wr` and buffer port.

## Interface
- `TIMEOUT_CYC`, default 24'hFFFFFF: cycles allowed per wait state before the transfer is aborted with an error.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `io_lba` in 32: sector address, sampled at request accept.
- `io_rd` in 1: read request (level); accepted on a rising edge.
- `io_wr` in 1: write request (level); accepted on a rising edge.
- `io_ack` out 1: one-cycle completion pulse.
- `sd_buff_addr` out 9: target buffer byte address.
- `sd_buff_dout` out 8: byte written into the target buffer.
- `sd_buff_wr` out 1: buffer write strobe, one cycle per byte.
- `sd_buff_din` in 8: buffer read data, valid one cycle after `sd_buff_addr`.
- `blk_lba` out 32: latched sector address to storage.
- `blk_req` out 1: block request, held until `blk_gnt`.
- `blk_we` out 1: request direction, 1 = write; valid while `blk_req` is high.
- `blk_gnt` in 1: storage accepted the request.
- `blk_done` in 1: storage finished the block (pulse).
- `blk_err` in 1: storage failure (pulse).
- `rx_data` in 8: read byte from storage.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: this block accepts `rx_data`.
- `tx_data` out 8: write byte to storage.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: storage accepts `tx_data`.
- `err` out 1: sticky error; cleared at the next request accept.

## Operation
- Edge detect: `io_rd` and `io_wr` are registered; a request is accepted in IDLE when the input is high now and was low in the previous cycle.
  - Both edges in the same cycle: read wins, write is discarded.
  - Edges arriving outside IDLE are discarded; they are not queued.
- On accept: latch `blk_lba <= io_lba`, set `blk_we`, clear `err`, zero the byte counter `cnt[9:0]`, enter REQ.
- REQ: `blk_req = 1`. On `blk_gnt` go to RD (read) or WRF (write).
- RD: `rx_ready = 1`. For each `rx_valid` byte:
  - register `sd_buff_addr <= cnt[8:0]`, `sd_buff_dout <= rx_data`, `sd_buff_wr <= 1` for one cycle;
  - increment `cnt`;
  - after byte 511 (`cnt` reaches 512) go to DONE.
- WRF: drive `sd_buff_addr = cnt[8:0]`, wait one cycle, latch `sd_buff_din` into `tx_data`, go to WRD.
- WRD: `tx_valid = 1`. On `tx_ready`:
  - increment `cnt`;
  - if `cnt` was 511 go to DONE, else go to WRF.
- DONE: wait for `blk_done` and go to ACK.
- ACK: `io_ack = 1` for exactly one cycle, then IDLE.
- Errors: `blk_err` in any non-IDLE state sets `err` and goes to ACK. The watchdog counter reloads on every state change and on every byte handshake; when it reaches `TIMEOUT_CYC` it sets `err` and goes to ACK. Every accepted request produces exactly one `io_ack`, so the target never hangs.
- `rx_ready` is 0 outside RD, so surplus bytes are not consumed. `tx_valid` is 0 outside WRD.

## Timing
- Reset values:
  - state IDLE;
  - `io_ack`, `blk_req`, `blk_we`, `sd_buff_wr`, `rx_ready`, `tx_valid`, `err` all 0;
  - `sd_buff_addr`, `sd_buff_dout`, `tx_data` 0;
  - `blk_lba` 0.
- Reset mid-transfer: immediate return to IDLE, no `io_ack`, `blk_req` dropped. Storage must abort on `blk_req` falling.
- Accept latency: `blk_req` rises 2 cycles after the `io_rd` edge (1 cycle edge register, 1 cycle accept).
- Read throughput: 1 byte/cycle. `sd_buff_wr` is asserted one cycle after the `rx_valid`&`rx_ready` cycle.
- Write throughput: 1 byte per 2 cycles minimum, plus `tx_ready` stalls.
- `io_ack` is asserted the cycle after `blk_done`, error, or timeout is seen.
- `blk_gnt`/`blk_done` asserted in the same cycle that REQ is entered is honoured on the next cycle only.

## Structure
- Shared package `sector_io_pkg`:
  - state enum (IDLE, REQ, RD, WRF, WRD, DONE, ACK);
  - `SECTOR_BYTES = 512`;
  - `BUF_AW = 9`.
- One sub-module, `sector_io_watchdog`: a loadable down-counter with timeout flag.

## Test plan
- Read LBA 32'h00000123; storage returns bytes `i^8'hA5` for i = 0..511 with random `rx_valid` gaps → 512 `sd_buff_wr` pulses at addresses 0..511 with matching data, `blk_lba` = 32'h123, one `io_ack`, `err` = 0.
- Write with buffer preloaded `buf[i] = i[7:0]`, `tx_ready` toggling → `tx_data` sequence 0..255, 0..255, `blk_we` = 1, one `io_ack` after `blk_done`.
- `io_rd` and `io_wr` rise in the same cycle → read transfer only. A second `io_rd` edge during RD is ignored, giving exactly one `io_ack`.
- `blk_err` pulse after byte 100 of a read → `err` = 1, `io_ack` pulse, `rx_ready` 0. The next request clears `err`.
- `TIMEOUT_CYC = 50`, `blk_gnt` never asserted → `io_ack` and `err` = 1 exactly 50 cycles after REQ is entered.
- `reset_n` low during WRD → all outputs take reset values asynchronously, no `io_ack`. A new `io_wr` edge after release restarts from address 0.
